// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matmul tile constants and collector state type
package matmul_pkg;
   localparam int TILE_M  = 2;
   localparam int TILE_N  = 2;
   localparam int C_BEATS = TILE_M * TILE_N;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DISCARD = 2'd1,
      FULL    = 2'd2
   } collector_state_t;
endpackage

// File: rtl/c_result_collector_if.sv
// rtl/c_result_collector_if.sv - C result stream bundle with source/sink modports
interface c_result_collector_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/c_result_collector.sv
// rtl/c_result_collector.sv - collects one C tile burst into a readable bank
// and holds it, with sticky flags, until software clears it.
module c_result_collector
   import matmul_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BEATS  = C_BEATS
) (
   input  logic                     clk,
   input  logic                     rst,
   c_result_collector_if.slave      s_axis_c,
   input  logic [$clog2(BEATS)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   input  logic                     clr,
   output logic                     result_valid,
   output logic                     err_len,
   output logic                     irq,
   output logic [$clog2(BEATS):0]   beat_cnt
);
   localparam int AW = $clog2(BEATS);
   localparam int CW = AW + 1;

   collector_state_t  state;
   collector_state_t  state_next;
   logic [DATA_W-1:0] bank [BEATS];
   logic              hs;
   logic              at_last;

   assign hs      = s_axis_c.tvalid && s_axis_c.tready;
   assign at_last = (beat_cnt == CW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: begin
            if (hs && at_last) state_next = s_axis_c.tlast ? FULL : DISCARD;
         end
         DISCARD: begin
            if (hs && s_axis_c.tlast) state_next = COLLECT;
         end
         FULL: begin
            if (clr) state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   // Ready is decoded from state only, so it never depends on tvalid.
   always_comb begin
      s_axis_c.tready = 1'b0;
      if (!rst && state != FULL) s_axis_c.tready = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt     <= '0;
         result_valid <= 1'b0;
         err_len      <= 1'b0;
         irq          <= 1'b0;
         rd_data      <= '0;
         for (int i = 0; i < BEATS; i++) bank[i] <= '0;
      end else begin
         rd_data <= bank[rd_addr];
         irq     <= 1'b0;
         if (clr) err_len <= 1'b0;
         case (state)
            COLLECT: begin
               if (hs) begin
                  bank[beat_cnt[AW-1:0]] <= s_axis_c.tdata;
                  if (s_axis_c.tlast || at_last) beat_cnt <= '0;
                  else                           beat_cnt <= beat_cnt + CW'(1);
                  // Any burst that does not end exactly on the last slot is a length error.
                  if (s_axis_c.tlast && at_last) begin
                     result_valid <= 1'b1;
                     irq          <= 1'b1;
                  end else if (s_axis_c.tlast || at_last) begin
                     err_len <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (clr) result_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_c_result_collector.sv
// tb/tb_c_result_collector.sv - randomized directed bench for c_result_collector
module tb_c_result_collector;
   import matmul_pkg::*;

   localparam int B = C_BEATS;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        clr;
   logic        result_valid;
   logic        err_len;
   logic        irq;
   logic [2:0]  beat_cnt;

   c_result_collector_if #(.DATA_W(32)) s_axis_c ();

   c_result_collector #(.DATA_W(32), .BEATS(B)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_c     (s_axis_c),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .clr          (clr),
      .result_valid (result_valid),
      .err_len      (err_len),
      .irq          (irq),
      .beat_cnt     (beat_cnt)
   );

   always #5 clk = ~clk;

   // Reference: the bank, the length of the burst in progress, and the sticky flags.
   logic [31:0] m_bank [B];
   int          m_len;
   bit          m_rv;
   bit          m_err;
   bit          m_irq;
   logic [31:0] m_rd;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("beat_cnt", 64'(beat_cnt), (m_len < B) ? 64'(m_len) : 64'd0);
      check("result_valid", 64'(result_valid), 64'(m_rv));
      check("err_len", 64'(err_len), 64'(m_err));
      check("irq", 64'(irq), 64'(m_irq));
      check("rd_data", 64'(rd_data), 64'(m_rd));
   endtask

   task automatic model_reset();
      for (int i = 0; i < B; i++) m_bank[i] = '0;
      m_len = 0;
      m_rv  = 0;
      m_err = 0;
      m_irq = 0;
      m_rd  = '0;
   endtask

   // One clock: drive, check ready, advance the model, check registered outputs.
   task automatic cycle(input logic [31:0] d, input bit v, input bit l, input bit c, input logic [1:0] a);
      bit hs;
      s_axis_c.tdata  = d;
      s_axis_c.tvalid = v;
      s_axis_c.tlast  = l;
      clr             = c;
      rd_addr         = a;
      #1;
      check("tready", 64'(s_axis_c.tready), 64'(!m_rv));
      hs    = v && !m_rv;
      m_rd  = m_bank[a];
      m_irq = 0;
      if (c) m_err = 0;
      if (m_rv) begin
         if (c) m_rv = 0;
      end else if (hs) begin
         if (m_len < B) m_bank[m_len] = d;
         m_len++;
         if (l) begin
            if (m_len == B) begin
               m_rv  = 1;
               m_irq = 1;
            end else if (m_len < B) begin
               m_err = 1;
            end
            m_len = 0;
         end else if (m_len == B) begin
            m_err = 1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle($urandom, 1'b0, 1'($urandom), 1'b0, 2'($urandom));
   endtask

   task automatic word(input logic [31:0] d, input bit l, input bit c);
      if ($urandom_range(0, 2) == 0) idle(1);
      cycle(d, 1'b1, l, c, 2'($urandom));
   endtask

   task automatic rand_burst(input int n, input bit clr_last);
      for (int i = 0; i < n; i++) word($urandom, i == n - 1, clr_last && (i == n - 1));
   endtask

   task automatic read_all();
      for (int i = 0; i < B; i++) cycle($urandom, 1'b0, 1'b0, 1'b0, 2'(i));
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      s_axis_c.tvalid = 1'b1;
      s_axis_c.tdata  = $urandom;
      s_axis_c.tlast  = 1'b0;
      clr             = 1'b0;
      rd_addr         = 2'($urandom);
      #1;
      check("tready_in_reset", 64'(s_axis_c.tready), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("tready_in_reset", 64'(s_axis_c.tready), 64'd0);
      check_outputs();
      rst = 1'b0;
   endtask

   initial begin
      s_axis_c.tdata  = '0;
      s_axis_c.tvalid = 1'b0;
      s_axis_c.tlast  = 1'b0;
      clr             = 1'b0;
      rd_addr         = '0;
      model_reset();
      do_reset();
      read_all();

      // Normal burst and readback.
      word(32'd11, 1'b0, 1'b0);
      word(32'd22, 1'b0, 1'b0);
      word(32'd33, 1'b0, 1'b0);
      word(32'd44, 1'b1, 1'b0);
      read_all();

      // Backpressure while FULL, then release and accept a new burst.
      for (int i = 0; i < 10; i++) cycle($urandom, 1'b1, 1'($urandom), 1'b0, 2'($urandom));
      read_all();
      cycle($urandom, 1'b1, 1'b0, 1'b1, 2'd0);
      rand_burst(B, 1'b0);
      read_all();
      cycle($urandom, 1'b0, 1'b0, 1'b1, 2'd0);

      // Short burst, then a good burst with err_len still set.
      word(32'd5, 1'b0, 1'b0);
      word(32'd6, 1'b1, 1'b0);
      read_all();
      rand_burst(B, 1'b0);
      read_all();
      cycle($urandom, 1'b0, 1'b0, 1'b1, 2'd0);

      // Long burst: words past the fourth are dropped.
      rand_burst(6, 1'b0);
      read_all();
      rand_burst(B, 1'b0);
      cycle($urandom, 1'b0, 1'b0, 1'b1, 2'd0);

      // clr on the completing handshake: completion wins, err_len clears.
      rand_burst(3, 1'b0);
      rand_burst(B, 1'b1);
      idle(2);
      cycle($urandom, 1'b0, 1'b0, 1'b1, 2'd0);

      // Reset mid-burst.
      rand_burst(2, 1'b0);
      s_axis_c.tlast = 1'b0;
      word($urandom, 1'b0, 1'b0);
      do_reset();
      rand_burst(B, 1'b0);
      read_all();
      cycle($urandom, 1'b0, 1'b0, 1'b1, 2'd0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         cycle($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, 2'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
